pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central sequencing unit for the 5-stage dual-slot (ALU + MEM) VLIW pipeline.
- Drives the write enables, flushes and bubble insert of the PC and the four pipeline register banks (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Resolves three events: load-use hazards, taken branches/jumps from EX, and multi-cycle data-memory accesses via a req/ready handshake with timeout.
- Keeps saturating stall/flush performance counters.

Parameters:
TIMEOUT, 200, max MEM_WAIT cycles before fatal halt (1..2^WAIT_W-1)
WAIT_W, 8, width of wait counter
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
id_alu_rn, id_alu_rm, id_mem_rn, id_mem_rd  in  3 each  source register fields of bundle in ID
id_alu_rn_used, id_alu_rm_used, id_mem_rn_used, id_mem_rd_used  in  1 each  field is a real source (mem_rd used = store data)
p2_memRead  in  1  ID/EX MEM slot is a load
p2_mem_regWrite  in  1  ID/EX MEM slot writes a register
p2_mem_rd  in  3  ID/EX MEM slot destination
branch_taken  in  1  EX resolved taken branch or jump
p3_memRead, p3_memWrite  in  1 each  EX/MEM holds a memory access
mem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC update enable
ifid_write, idex_write, exmem_write, memwb_write  out  1 each  bank enables (regWrite of each bank)
IF_flush, ID_flush, EX_flush  out  1 each  bank flushes
p2_pipeline_stall  out  1  bubble: zero ID/EX control signals
mem_req  out  1  access request to data memory
halted  out  1  controller in HALT
mem_timeout  out  1  sticky: HALT caused by timeout
stall_cycles  out  CNT_W  cycles with any freeze or bubble, saturating
flush_events  out  CNT_W  taken-branch flushes, saturating

Behaviour:
States: RUN, MEM_WAIT, HALT. Reset -> RUN, wait_cnt=0, counters=0, mem_timeout=0.
While reset is high: all enables, flushes, p2_pipeline_stall and mem_req are forced to 0.
mem_access = p3_memRead | p3_memWrite.
lu_hazard = p2_memRead & p2_mem_regWrite & (any used ID source field == p2_mem_rd). No r0 exemption.

RUN:
- If mem_access & !mem_ready: freeze (all enables 0, no flush, no bubble), mem_req=1; next MEM_WAIT, wait_cnt=1.
- Else, mem_req=mem_access (zero-wait access completes now), then:
  - If branch_taken: all enables 1, IF_flush=1, ID_flush=1, p2_pipeline_stall=0, flush_events+1. The branch has priority over lu_hazard because the hazard bundle is flushed.
  - Else if lu_hazard: pc_write=0, ifid_write=0, idex/exmem/memwb_write=1, p2_pipeline_stall=1 (exactly one bubble).
  - Else: all enables 1, no flush/bubble.

MEM_WAIT:
- mem_req=1, all EX/ID/IF state frozen; branch_taken and lu_hazard are held and ignored.
- On mem_ready: apply the RUN advance rules for this cycle (branch/hazard evaluated now); next RUN, wait_cnt=0.
- Else wait_cnt+1. When wait_cnt==TIMEOUT and !mem_ready: next HALT.
- mem_ready in the same cycle as reaching TIMEOUT wins (no halt).

HALT:
- All enables 0, mem_req=0, EX_flush=1, halted=1, mem_timeout=1.
- Only reset exits HALT.

Counters:
- stall_cycles +1 in any cycle where pc_write==0 (includes every cycle in HALT).
- Both counters saturate at all-ones.

All control outputs are combinational from state + inputs. State, wait_cnt, counters and mem_timeout are registered. Reset mid-MEM_WAIT returns to RUN with mem_req=0 immediately.

Test Plan:
1. Load-use: p2_memRead=1, p2_mem_regWrite=1, p2_mem_rd=3, id_alu_rm=3, rm_used=1 -> exactly one cycle of pc_write=0, ifid_write=0, p2_pipeline_stall=1, idex_write=1; stall_cycles=1.
2. Unused field: same as 1 but rm_used=0 -> no stall. Store data: id_mem_rd=3, mem_rd_used=1 -> stall.
3. Branch + hazard same cycle: branch_taken=1 with lu_hazard -> IF_flush=ID_flush=1, pc_write=1, p2_pipeline_stall=0; flush_events=1.
4. Memory wait: p3_memRead=1, mem_ready low 3 cycles then high -> 3 frozen cycles with mem_req=1, advance on 4th; stall_cycles=3. With mem_ready=1 immediately -> 0 stall.
5. Timeout: TIMEOUT=4, mem_ready never -> HALT after 4 MEM_WAIT cycles, halted=1, mem_timeout=1, EX_flush=1. Async reset mid-HALT -> RUN, outputs cleared.
6. Saturation: CNT_W=4, 20 hazard cycles -> stall_cycles holds 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Stall/flush/bubble sequencer for the 5-stage dual-slot VLIW pipe.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 200,
    parameter int WAIT_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       id_alu_rn,
    input  logic [2:0]       id_alu_rm,
    input  logic [2:0]       id_mem_rn,
    input  logic [2:0]       id_mem_rd,
    input  logic             id_alu_rn_used,
    input  logic             id_alu_rm_used,
    input  logic             id_mem_rn_used,
    input  logic             id_mem_rd_used,
    input  logic             p2_memRead,
    input  logic             p2_mem_regWrite,
    input  logic [2:0]       p2_mem_rd,
    input  logic             branch_taken,
    input  logic             p3_memRead,
    input  logic             p3_memWrite,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             memwb_write,
    output logic             IF_flush,
    output logic             ID_flush,
    output logic             EX_flush,
    output logic             p2_pipeline_stall,
    output logic             mem_req,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    localparam logic [WAIT_W-1:0] C_TIMEOUT  = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] C_WAIT_ONE = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX  = '1;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic              r_mem_timeout;

    logic w_mem_access;
    logic w_lu_hazard;
    logic w_advance;
    logic w_flush_event;

    assign w_mem_access = p3_memRead | p3_memWrite;

    // No r0 exemption: a load to r0 still stalls a dependent consumer.
    assign w_lu_hazard = p2_memRead & p2_mem_regWrite &
                         ((id_alu_rn_used & (id_alu_rn == p2_mem_rd)) |
                          (id_alu_rm_used & (id_alu_rm == p2_mem_rd)) |
                          (id_mem_rn_used & (id_mem_rn == p2_mem_rd)) |
                          (id_mem_rd_used & (id_mem_rd == p2_mem_rd)));

    always_comb begin
        pc_write          = 1'b0;
        ifid_write        = 1'b0;
        idex_write        = 1'b0;
        exmem_write       = 1'b0;
        memwb_write       = 1'b0;
        IF_flush          = 1'b0;
        ID_flush          = 1'b0;
        EX_flush          = 1'b0;
        p2_pipeline_stall = 1'b0;
        mem_req           = 1'b0;
        w_advance         = 1'b0;
        w_flush_event     = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_RUN: begin
                    mem_req   = w_mem_access;
                    w_advance = !(w_mem_access && !mem_ready);
                end
                ST_MEM_WAIT: begin
                    mem_req   = 1'b1;
                    w_advance = mem_ready;
                end
                ST_HALT: begin
                    EX_flush = 1'b1;
                end
                default: ;
            endcase

            // Branch wins over a hazard: the hazarding bundle is flushed anyway.
            if (w_advance) begin
                if (branch_taken) begin
                    pc_write      = 1'b1;
                    ifid_write    = 1'b1;
                    idex_write    = 1'b1;
                    exmem_write   = 1'b1;
                    memwb_write   = 1'b1;
                    IF_flush      = 1'b1;
                    ID_flush      = 1'b1;
                    w_flush_event = 1'b1;
                end else if (w_lu_hazard) begin
                    idex_write        = 1'b1;
                    exmem_write       = 1'b1;
                    memwb_write       = 1'b1;
                    p2_pipeline_stall = 1'b1;
                end else begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    idex_write  = 1'b1;
                    exmem_write = 1'b1;
                    memwb_write = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_access && !mem_ready) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= C_WAIT_ONE;
                    end
                end
                ST_MEM_WAIT: begin
                    // A ready arriving on the timeout cycle still completes.
                    if (mem_ready) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == C_TIMEOUT) begin
                        r_state       <= ST_HALT;
                        r_mem_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + C_WAIT_ONE;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase

            if (!pc_write && (r_stall_cnt != C_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
            if (w_flush_event && (r_flush_cnt != C_CNT_MAX))
                r_flush_cnt <= r_flush_cnt + C_CNT_ONE;
        end
    end

    assign halted       = (r_state == ST_HALT);
    assign mem_timeout  = r_mem_timeout;
    assign stall_cycles = r_stall_cnt;
    assign flush_events = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Directed scoreboard bench for pipeline_hazard_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int C_CNT_W = 4;

    // {pc, ifid, idex, exmem, memwb, IF_fl, ID_fl, EX_fl, bubble, req, halted, tmo}
    localparam logic [11:0] C_ZERO    = 12'b000000000000;
    localparam logic [11:0] C_ADV     = 12'b111110000000;
    localparam logic [11:0] C_ADV_REQ = 12'b111110000100;
    localparam logic [11:0] C_BR      = 12'b111111100000;
    localparam logic [11:0] C_BR_REQ  = 12'b111111100100;
    localparam logic [11:0] C_HZ      = 12'b001110001000;
    localparam logic [11:0] C_FRZ     = 12'b000000000100;
    localparam logic [11:0] C_HALT    = 12'b000000010011;

    typedef struct packed {
        logic [11:0]        ctrl;
        logic [C_CNT_W-1:0] stall;
        logic [C_CNT_W-1:0] flush;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [2:0] id_alu_rn, id_alu_rm, id_mem_rn, id_mem_rd, p2_mem_rd;
    logic id_alu_rn_used, id_alu_rm_used, id_mem_rn_used, id_mem_rd_used;
    logic p2_memRead, p2_mem_regWrite, branch_taken;
    logic p3_memRead, p3_memWrite, mem_ready;
    logic pc_write, ifid_write, idex_write, exmem_write, memwb_write;
    logic IF_flush, ID_flush, EX_flush, p2_pipeline_stall, mem_req;
    logic halted, mem_timeout;
    logic [C_CNT_W-1:0] stall_cycles, flush_events;
    logic [11:0] obs;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .TIMEOUT (4),
        .WAIT_W  (8),
        .CNT_W   (C_CNT_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .id_alu_rn         (id_alu_rn),
        .id_alu_rm         (id_alu_rm),
        .id_mem_rn         (id_mem_rn),
        .id_mem_rd         (id_mem_rd),
        .id_alu_rn_used    (id_alu_rn_used),
        .id_alu_rm_used    (id_alu_rm_used),
        .id_mem_rn_used    (id_mem_rn_used),
        .id_mem_rd_used    (id_mem_rd_used),
        .p2_memRead        (p2_memRead),
        .p2_mem_regWrite   (p2_mem_regWrite),
        .p2_mem_rd         (p2_mem_rd),
        .branch_taken      (branch_taken),
        .p3_memRead        (p3_memRead),
        .p3_memWrite       (p3_memWrite),
        .mem_ready         (mem_ready),
        .pc_write          (pc_write),
        .ifid_write        (ifid_write),
        .idex_write        (idex_write),
        .exmem_write       (exmem_write),
        .memwb_write       (memwb_write),
        .IF_flush          (IF_flush),
        .ID_flush          (ID_flush),
        .EX_flush          (EX_flush),
        .p2_pipeline_stall (p2_pipeline_stall),
        .mem_req           (mem_req),
        .halted            (halted),
        .mem_timeout       (mem_timeout),
        .stall_cycles      (stall_cycles),
        .flush_events      (flush_events)
    );

    assign obs = {pc_write, ifid_write, idex_write, exmem_write, memwb_write,
                  IF_flush, ID_flush, EX_flush, p2_pipeline_stall, mem_req,
                  halted, mem_timeout};

    task automatic clear_inputs();
        id_alu_rn = 3'd1; id_alu_rm = 3'd2; id_mem_rn = 3'd4; id_mem_rd = 3'd5;
        id_alu_rn_used = 1'b0; id_alu_rm_used = 1'b0;
        id_mem_rn_used = 1'b0; id_mem_rd_used = 1'b0;
        p2_memRead = 1'b0; p2_mem_regWrite = 1'b0; p2_mem_rd = 3'd0;
        branch_taken = 1'b0; p3_memRead = 1'b0; p3_memWrite = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic push_exp(input logic [11:0] c, input int s, input int f);
        exp_t e;
        e.ctrl  = c;
        e.stall = C_CNT_W'(s);
        e.flush = C_CNT_W'(f);
        q.push_back(e);
    endtask

    task automatic check_now(input string tag);
        exp_t e;
        vectors++;
        assert (q.size() > 0) else begin
            miscompares++;
            $error("FAIL %s scoreboard empty", tag);
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            assert (obs === e.ctrl) else begin
                miscompares++;
                $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, e.ctrl);
            end
            vectors++;
            assert (stall_cycles === e.stall) else begin
                miscompares++;
                $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, stall_cycles, e.stall);
            end
            vectors++;
            assert (flush_events === e.flush) else begin
                miscompares++;
                $error("FAIL %s flush_events observed=%0d expected=%0d", tag, flush_events, e.flush);
            end
        end
    endtask

    // Outputs sampled on the falling edge, inputs changed just after the rising edge.
    task automatic exp_cycle(input string tag, input logic [11:0] c, input int s, input int f);
        push_exp(c, s, f);
        @(negedge clk);
        check_now(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #2;
        push_exp(C_ZERO, 0, 0);
        check_now("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cycle("idle", C_ADV, 0, 0);

        p2_memRead = 1'b1; p2_mem_regWrite = 1'b1; p2_mem_rd = 3'd3;
        id_alu_rm = 3'd3; id_alu_rm_used = 1'b1;
        exp_cycle("lu_rm", C_HZ, 0, 0);
        clear_inputs();
        exp_cycle("lu_rm_after", C_ADV, 1, 0);

        p2_memRead = 1'b1; p2_mem_regWrite = 1'b1; p2_mem_rd = 3'd3;
        id_alu_rm = 3'd3; id_alu_rm_used = 1'b0;
        exp_cycle("lu_unused", C_ADV, 1, 0);
        id_mem_rd = 3'd3; id_mem_rd_used = 1'b1;
        exp_cycle("lu_store", C_HZ, 1, 0);
        clear_inputs();
        exp_cycle("lu_store_after", C_ADV, 2, 0);

        p2_memRead = 1'b1; p2_mem_regWrite = 1'b1; p2_mem_rd = 3'd0;
        id_alu_rn = 3'd0; id_alu_rn_used = 1'b1;
        exp_cycle("lu_r0", C_HZ, 2, 0);
        p2_mem_regWrite = 1'b0;
        exp_cycle("lu_nowrite", C_ADV, 3, 0);

        p2_mem_regWrite = 1'b1; branch_taken = 1'b1;
        exp_cycle("br_hazard", C_BR, 3, 0);
        clear_inputs();
        exp_cycle("br_after", C_ADV, 3, 1);

        p3_memRead = 1'b1;
        exp_cycle("mw0", C_FRZ, 3, 1);
        exp_cycle("mw1", C_FRZ, 4, 1);
        exp_cycle("mw2", C_FRZ, 5, 1);
        mem_ready = 1'b1;
        exp_cycle("mw_done", C_ADV_REQ, 6, 1);
        clear_inputs();
        exp_cycle("mw_after", C_ADV, 6, 1);

        p3_memRead = 1'b1; mem_ready = 1'b1;
        exp_cycle("mem_zero_wait", C_ADV_REQ, 6, 1);
        clear_inputs();
        exp_cycle("mem_zero_after", C_ADV, 6, 1);

        p3_memWrite = 1'b1;
        exp_cycle("mwb0", C_FRZ, 6, 1);
        mem_ready = 1'b1; branch_taken = 1'b1;
        exp_cycle("mwb_branch", C_BR_REQ, 7, 1);
        clear_inputs();
        exp_cycle("mwb_after", C_ADV, 7, 2);

        p3_memRead = 1'b1;
        exp_cycle("to_run", C_FRZ, 7, 2);
        exp_cycle("to_w1", C_FRZ, 8, 2);
        exp_cycle("to_w2", C_FRZ, 9, 2);
        exp_cycle("to_w3", C_FRZ, 10, 2);
        exp_cycle("to_w4", C_FRZ, 11, 2);
        exp_cycle("halt0", C_HALT, 12, 2);
        mem_ready = 1'b1;
        exp_cycle("halt1", C_HALT, 13, 2);

        reset = 1'b1;
        #1;
        push_exp(C_ZERO, 0, 0);
        check_now("async_reset");
        clear_inputs();
        @(posedge clk); #1;
        reset = 1'b0;

        p3_memRead = 1'b1;
        exp_cycle("tb_run", C_FRZ, 0, 0);
        exp_cycle("tb_w1", C_FRZ, 1, 0);
        exp_cycle("tb_w2", C_FRZ, 2, 0);
        exp_cycle("tb_w3", C_FRZ, 3, 0);
        mem_ready = 1'b1;
        exp_cycle("tb_w4_ready", C_ADV_REQ, 4, 0);
        clear_inputs();
        exp_cycle("tb_after", C_ADV, 4, 0);

        p2_memRead = 1'b1; p2_mem_regWrite = 1'b1; p2_mem_rd = 3'd6;
        id_mem_rn = 3'd6; id_mem_rn_used = 1'b1;
        for (int i = 0; i < 20; i++)
            exp_cycle("sat", C_HZ, (4 + i > 15) ? 15 : 4 + i, 0);
        clear_inputs();
        exp_cycle("sat_hold", C_ADV, 15, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
